decode_stage_skid: RTL

//  Registered, parametrised MIPS instruction decode stage: splits R/I/J fields, classifies type,

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/decode_stage_skid_if.sv | 35 +++
 rtl/instr_field_extract.sv | 39 +++
 rtl/decode_stage_skid.sv | 81 ++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: MIPS opcode constants, type codes, skid-buffer states and the type classifier
package decoder_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [1:0] TYPE_R   = 2'b00;
  localparam logic [1:0] TYPE_I   = 2'b01;
  localparam logic [1:0] TYPE_J   = 2'b10;
  localparam logic [1:0] TYPE_RSV = 2'b11;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
  // Opcodes 0x10-0x13 are the coprocessor group, which share the top four bits 0100
  function automatic logic [1:0] instr_type(input logic [5:0] op);
    return op == OP_RTYPE ? TYPE_R :
           (op == OP_J || op == OP_JAL) ? TYPE_J :
           op[5:2] == 4'b0100 ? TYPE_RSV : TYPE_I;
  endfunction
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return op == OP_ANDI || op == OP_ORI || op == OP_XORI;
  endfunction
endpackage

// File: rtl/decode_stage_skid_if.sv
// decode_stage_skid_if: fetch-side and decode-side valid/ready bundle of the decode stage
interface decode_stage_skid_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 7
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_type;
  logic [OPC_W-1:0]   out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [4:0]         out_shamt;
  logic [5:0]         out_funct;
  logic [DATA_W-1:0]  out_imm_ext;
  logic [PC_W-1:0]    out_jump_tgt;
  logic [PC_W-1:0]    out_pc;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_type, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm_ext, out_jump_tgt, out_pc
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_type, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm_ext, out_jump_tgt, out_pc
  );
endinterface

// File: rtl/instr_field_extract.sv
// instr_field_extract: combinational MIPS field split, type, immediate extension and jump target
module instr_field_extract
  import decoder_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 7
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic [1:0]         typ,
  output logic [OPC_W-1:0]   opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [PC_W-1:0]    jump_tgt
);
  localparam logic [PC_W-1:0] REGION_MASK = ~PC_W'(28'hFFF_FFFF);
  logic [5:0]      op;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc_plus4;
  always_comb begin
    op = instr[31:26];
    imm = instr[15:0];
    typ = instr_type(op);
    opcode = OPC_W'(op);
    {rs, rt, rd, shamt, funct} = instr[25:0];
    imm_ext = op == OP_LUI ? DATA_W'({imm, 16'h0000}) :
              imm_zero_ext(op) ? DATA_W'(imm) :
              {{(DATA_W-16){imm[15]}}, imm};
    pc_plus4 = pc + PC_W'(4);
    // Keep the 256 MB region of pc+4 and drop in the word-aligned 26-bit index
    jump_tgt = (pc_plus4 & REGION_MASK) | PC_W'({instr[25:0], 2'b00});
  end
endmodule

// File: rtl/decode_stage_skid.sv
// decode_stage_skid: registered MIPS decode stage with a two-entry skid buffer on valid/ready
module decode_stage_skid
  import decoder_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 7
) (
  input logic clk,
  input logic rst,
  decode_stage_skid_if.slave io
);
  localparam int ENT_W = 2 + OPC_W + 26 + DATA_W + 2 * PC_W;
  state_e            state_q, state_d;
  logic [ENT_W-1:0]  main_q, main_d, skid_q, skid_d, dec_ent;
  logic [1:0]        dec_type;
  logic [OPC_W-1:0]  dec_opcode;
  logic [4:0]        dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [5:0]        dec_funct;
  logic [DATA_W-1:0] dec_imm;
  logic [PC_W-1:0]   dec_tgt;
  logic              acc, pop, load_main, load_skid, skid_to_main;
  instr_field_extract #(
    .INSTR_W(INSTR_W),
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_extract (
    .instr   (io.in_instr),
    .pc      (io.in_pc),
    .typ     (dec_type),
    .opcode  (dec_opcode),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd),
    .shamt   (dec_shamt),
    .funct   (dec_funct),
    .imm_ext (dec_imm),
    .jump_tgt(dec_tgt)
  );
  assign dec_ent = {dec_type, dec_opcode, dec_rs, dec_rt, dec_rd, dec_shamt, dec_funct,
                    dec_imm, dec_tgt, io.in_pc};
  assign {io.out_type, io.out_opcode, io.out_rs, io.out_rt, io.out_rd, io.out_shamt,
          io.out_funct, io.out_imm_ext, io.out_jump_tgt, io.out_pc} = main_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  // in_ready depends only on state and rst, so out_ready never reaches it combinationally
  always_comb begin
    io.out_valid = state_q != ST_EMPTY;
    io.in_ready = state_q != ST_FULL && !rst;
    acc = io.in_valid && io.in_ready;
    pop = io.out_valid && io.out_ready;
    load_main = acc && (state_q == ST_EMPTY || pop);
    load_skid = acc && state_q == ST_ONE && !pop;
    skid_to_main = pop && state_q == ST_FULL;
  end
  always_comb begin
    state_d = ST_EMPTY;
    case (state_q)
      ST_EMPTY: state_d = acc ? ST_ONE : ST_EMPTY;
      ST_ONE:   state_d = (acc && !pop) ? ST_FULL : (pop && !acc) ? ST_EMPTY : ST_ONE;
      ST_FULL:  state_d = pop ? ST_ONE : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    if (io.flush) state_d = ST_EMPTY;
  end
  always_comb begin
    main_d = load_main ? dec_ent : skid_to_main ? skid_q : main_q;
    skid_d = load_skid ? dec_ent : skid_q;
  end
endmodule
